// File: rtl/wram_sub_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : wram_sub_sched_if
//  Description : Request/ack and WRAM bank-port bundle between the sub-side
//                requesters (CDC DMA, graphics ASIC, sub CPU), the bank port
//                and the sub-side WRAM scheduler.
//                ctrl layout: {mode[1:0], mask[3:0], addr[16:1], din[15:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
interface wram_sub_sched_if;
    logic        sub_sync;
    logic        bank_own;
    logic        dma_req;
    logic        asic_req;
    logic        sub_req;
    logic [37:0] dma_ctrl;
    logic [37:0] asic_ctrl;
    logic [37:0] sub_ctrl;
    logic [15:0] mem_dout;
    logic [37:0] mem_ctrl;
    logic        dma_ack;
    logic        asic_ack;
    logic        sub_ack;
    logic [15:0] rd_data;
    logic        busy;
    logic        halt_req;

    // Scheduler side
    modport slave (
        input  sub_sync, bank_own,
        input  dma_req, asic_req, sub_req,
        input  dma_ctrl, asic_ctrl, sub_ctrl,
        input  mem_dout,
        output mem_ctrl,
        output dma_ack, asic_ack, sub_ack,
        output rd_data, busy, halt_req
    );

    // Requester / bank-port side
    modport master (
        output sub_sync, bank_own,
        output dma_req, asic_req, sub_req,
        output dma_ctrl, asic_ctrl, sub_ctrl,
        output mem_dout,
        input  mem_ctrl,
        input  dma_ack, asic_ack, sub_ack,
        input  rd_data, busy, halt_req
    );
endinterface
`default_nettype wire

// File: rtl/wram_sub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wram_sub_sched
//  Description : Sub-side WRAM bank scheduler. Arbitrates CDC DMA, graphics
//                ASIC and sub CPU onto one WRAM bank port, holds the port for
//                ACC_CYC enabled cycles, captures read data and pulses the
//                winner's ack. A sub CPU request waiting MAX_WAIT enabled
//                cycles is promoted above DMA/ASIC. All state moves on the
//                falling edge of clk_asic, qualified by sub_sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module wram_sub_sched #(
    parameter int ACC_CYC  = 2,
    parameter int MAX_WAIT = 15
) (
    input  wire logic       clk_asic,
    input  wire logic       cd_rst_n,
    wram_sub_sched_if.slave bus
);

    localparam int c_WAIT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int c_CNT_W   = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0]  c_CNT_INIT = c_CNT_W'(ACC_CYC - 1);
    localparam int c_MASK_HI = 35;
    localparam int c_MASK_LO = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_DMA  = 2'd0,
        WIN_ASIC = 2'd1,
        WIN_SUB  = 2'd2
    } win_t;

    state_t              r_state;
    state_t              w_state_nxt;
    win_t                r_winner;
    win_t                w_pick;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [37:0]         r_mem_ctrl;
    logic [37:0]         w_pick_ctrl;
    logic [15:0]         r_rd_data;
    logic [2:0]          r_ack;        // {sub, asic, dma}
    logic [2:0]          w_win_onehot;
    logic                w_any_req;
    logic                w_grant;
    logic                w_sub_urgent;
    logic                w_sub_active;
    logic                w_acc_done;

    // Arbitration: starved sub CPU first, otherwise fixed DMA > ASIC > SUB
    always_comb begin
        w_any_req    = bus.dma_req | bus.asic_req | bus.sub_req;
        w_grant      = (r_state == ST_IDLE) && bus.bank_own && w_any_req;
        w_sub_urgent = (r_wait_cnt == c_WAIT_MAX) && bus.sub_req;
        w_sub_active = (r_winner == WIN_SUB) && (r_state != ST_IDLE);
        w_acc_done   = (r_cnt == '0);
        w_pick       = WIN_SUB;
        w_pick_ctrl  = bus.sub_ctrl;
        if (w_sub_urgent) begin
            w_pick      = WIN_SUB;
            w_pick_ctrl = bus.sub_ctrl;
        end else if (bus.dma_req) begin
            w_pick      = WIN_DMA;
            w_pick_ctrl = bus.dma_ctrl;
        end else if (bus.asic_req) begin
            w_pick      = WIN_ASIC;
            w_pick_ctrl = bus.asic_ctrl;
        end
        case (r_winner)
            WIN_DMA:  w_win_onehot = 3'b001;
            WIN_ASIC: w_win_onehot = 3'b010;
            WIN_SUB:  w_win_onehot = 3'b100;
            default:  w_win_onehot = 3'b000;
        endcase
    end

    // Next-state logic: IDLE -> ACC (ACC_CYC cycles) -> ACK -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)    w_state_nxt = ST_ACC;
            ST_ACC:  if (w_acc_done) w_state_nxt = ST_ACK;
            ST_ACK:                  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; frozen while sub_sync is low
    always_ff @(negedge clk_asic or negedge cd_rst_n) begin
        if (!cd_rst_n) begin
            r_state <= ST_IDLE;
        end else if (bus.sub_sync) begin
            r_state <= w_state_nxt;
        end
    end

    // Port bundle, access counter, read capture and ack pulses. The ACK-state
    // actions (capture, ack, mask clear) are registered on the edge that
    // enters ACK so they are visible for the whole ACK cycle.
    always_ff @(negedge clk_asic or negedge cd_rst_n) begin
        if (!cd_rst_n) begin
            r_mem_ctrl <= '0;
            r_winner   <= WIN_DMA;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_ack      <= 3'b000;
        end else if (bus.sub_sync) begin
            r_ack <= 3'b000;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_mem_ctrl <= w_pick_ctrl;
                        r_winner   <= w_pick;
                        r_cnt      <= c_CNT_INIT;
                    end else begin
                        r_mem_ctrl[c_MASK_HI:c_MASK_LO] <= 4'b0000;
                    end
                end
                ST_ACC: begin
                    if (w_acc_done) begin
                        r_rd_data                       <= bus.mem_dout;
                        r_ack                           <= w_win_onehot;
                        r_mem_ctrl[c_MASK_HI:c_MASK_LO] <= 4'b0000;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sub CPU starvation counter: counts enabled cycles spent waiting
    always_ff @(negedge clk_asic or negedge cd_rst_n) begin
        if (!cd_rst_n) begin
            r_wait_cnt <= '0;
        end else if (bus.sub_sync) begin
            if (!bus.sub_req || w_sub_active || (w_grant && (w_pick == WIN_SUB))) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_ctrl = r_mem_ctrl;
    assign bus.dma_ack  = r_ack[0];
    assign bus.asic_ack = r_ack[1];
    assign bus.sub_ack  = r_ack[2];
    assign bus.rd_data  = r_rd_data;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.halt_req = bus.sub_req & ~w_sub_active;

endmodule
`default_nettype wire

// File: tb/tb_wram_sub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wram_sub_sched
//  Description : Randomised scoreboard bench for wram_sub_sched. A timestamp
//                model predicts grants and ack edges; a monitor compares
//                acks, read data, port bundle, busy and halt_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wram_sub_sched;

    localparam int ACC_CYC  = 2;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  t_req;          // {sub, asic, dma}
    logic [37:0] t_ctrl [3];
    logic [2:0]  w_ack;

    wram_sub_sched_if bus ();

    wram_sub_sched #(
        .ACC_CYC  (ACC_CYC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_asic (clk),
        .cd_rst_n (rst_n),
        .bus      (bus)
    );

    assign bus.dma_req   = t_req[0];
    assign bus.asic_req  = t_req[1];
    assign bus.sub_req   = t_req[2];
    assign bus.dma_ctrl  = t_ctrl[0];
    assign bus.asic_ctrl = t_ctrl[1];
    assign bus.sub_ctrl  = t_ctrl[2];
    assign w_ack         = {bus.sub_ack, bus.asic_ack, bus.dma_ack};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          who;
        logic [37:0] ctrl;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] hist [0:32767];   // mem_dout seen at each enabled edge
    int          n_en      = 0;    // enabled edges so far
    int          g_edge    = -1000;// edge of the latest grant
    int          next_free = 0;    // first edge at which a new grant can occur
    int          cur_who   = 0;
    logic [37:0] cur_ctrl  = '0;
    int          wt        = 0;
    bit          e_acc     = 1'b0;
    bit          e_busy    = 1'b0;
    bit          e_halt    = 1'b0;

    initial begin
        forever begin
            int  w;
            bit  grant_sub;
            bit  sub_was_active;
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                g_edge    = -1000;
                next_free = 0;
                wt        = 0;
                cur_who   = 0;
                sb_q.delete();
            end else if (bus.sub_sync) begin
                n_en++;
                hist[n_en]     = bus.mem_dout;
                sub_was_active = (cur_who == 2) && (g_edge < n_en) && (n_en < next_free);
                grant_sub      = 1'b0;
                if ((n_en >= next_free) && bus.bank_own && (t_req != 3'b000)) begin
                    if ((wt == MAX_WAIT) && t_req[2]) w = 2;
                    else if (t_req[0])                w = 0;
                    else if (t_req[1])                w = 1;
                    else                              w = 2;
                    g_edge    = n_en;
                    next_free = n_en + ACC_CYC + 2;
                    cur_who   = w;
                    cur_ctrl  = t_ctrl[w];
                    sb_q.push_back('{w, t_ctrl[w], n_en + ACC_CYC});
                    grant_sub = (w == 2);
                end
                if (!t_req[2] || grant_sub || sub_was_active) wt = 0;
                else if (wt < MAX_WAIT)                      wt++;
            end
            e_acc  = (n_en >= g_edge) && (n_en <= g_edge + ACC_CYC - 1);
            e_busy = (n_en >= g_edge) && (n_en <= g_edge + ACC_CYC);
            e_halt = t_req[2] && !(e_busy && (cur_who == 2));
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int          mon_last_n = 0;
        logic [2:0]  exp_ack    = 3'b000;
        logic [15:0] exp_rd     = '0;
        exp_t        e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_ack = 3'b000;
                exp_rd  = '0;
                chk("rst_ack",      w_ack,        3'b000);
                chk("rst_mem_ctrl", bus.mem_ctrl, 38'h0);
                chk("rst_rd_data",  bus.rd_data,  16'h0);
                chk("rst_busy",     bus.busy,     1'b0);
                chk("rst_halt",     bus.halt_req, t_req[2]);
            end else begin
                if (n_en != mon_last_n) begin
                    mon_last_n = n_en;
                    exp_ack    = 3'b000;
                    if ((sb_q.size() > 0) && (sb_q[0].due == n_en)) begin
                        e       = sb_q.pop_front();
                        exp_ack = 3'(1 << e.who);
                        exp_rd  = hist[e.due];
                    end
                end
                chk("ack",      w_ack,        exp_ack);
                chk("rd_data",  bus.rd_data,  exp_rd);
                chk("busy",     bus.busy,     e_busy);
                chk("halt_req", bus.halt_req, e_halt);
                if (e_acc) chk("mem_ctrl", bus.mem_ctrl, cur_ctrl);
                else       chk("mem_mask", bus.mem_ctrl[35:32], 4'b0000);
            end
        end
    end

    // ---------------- stimulus ----------------
    int g_own       = 100;
    int g_sync      = 100;
    int g_keep      = 0;
    int g_raise [3] = '{0, 0, 0};
    bit g_hold  [3] = '{0, 0, 0};
    bit g_rand_dout = 1'b0;

    function automatic logic [37:0] rnd_ctrl();
        return {6'($urandom), 32'($urandom)};
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            bus.sub_sync = ($urandom_range(99) < 32'(g_sync));
            bus.bank_own = ($urandom_range(99) < 32'(g_own));
            if (g_rand_dout) bus.mem_dout = 16'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (t_req[i] && w_ack[i]) begin
                    if (g_hold[i] || ($urandom_range(99) < 32'(g_keep))) t_ctrl[i] = rnd_ctrl();
                    else                                                   t_req[i]  = 1'b0;
                end else if (!t_req[i] && ($urandom_range(99) < 32'(g_raise[i]))) begin
                    t_req[i]  = 1'b1;
                    t_ctrl[i] = rnd_ctrl();
                end
            end
        end
    endtask

    initial begin
        // Reset with a sub CPU request already waiting
        rst_n        = 1'b0;
        bus.sub_sync = 1'b1;
        bus.bank_own = 1'b1;
        bus.mem_dout = 16'hA55A;
        t_ctrl[0]    = '0;
        t_ctrl[1]    = '0;
        t_ctrl[2]    = 38'h2B_1234_C0DE;
        t_req        = 3'b100;
        run(3);
        rst_n = 1'b1;
        run(8);

        // All three requesters at once
        g_rand_dout = 1'b1;
        for (int i = 0; i < 3; i++) t_ctrl[i] = rnd_ctrl();
        t_req = 3'b111;
        run(16);

        // DMA keeps re-requesting; sub CPU must still get through
        g_hold  = '{1, 0, 0};
        g_raise = '{100, 0, 100};
        t_req   = t_req | 3'b101;
        run(40);
        g_hold  = '{0, 0, 0};
        g_raise = '{0, 0, 0};
        run(12);

        // No bank ownership, then ownership toggling under ASIC traffic
        g_own   = 0;
        g_raise = '{0, 100, 0};
        run(10);
        g_own   = 50;
        g_raise = '{20, 60, 20};
        run(40);

        // Clock enable toggling
        g_own   = 100;
        g_sync  = 50;
        g_raise = '{50, 50, 50};
        run(60);

        // Asynchronous reset while an access is in ACC
        g_sync = 100;
        for (int k = 0; k < 50 && !e_acc; k++) run(1);
        chk("acc_reached", e_acc, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_ctrl", bus.mem_ctrl, 38'h0);
        chk("async_ack",      w_ack,        3'b000);
        chk("async_busy",     bus.busy,     1'b0);
        g_raise = '{0, 0, 0};
        run(2);
        rst_n = 1'b1;
        run(20);

        // Random soak
        for (int blk = 0; blk < 6; blk++) begin
            g_own   = int'($urandom_range(100, 50));
            g_sync  = int'($urandom_range(100, 40));
            g_keep  = int'($urandom_range(60));
            g_raise = '{int'($urandom_range(80)), int'($urandom_range(80)), int'($urandom_range(80))};
            run(400);
        end

        // Drain
        g_own   = 100;
        g_sync  = 100;
        g_keep  = 0;
        g_raise = '{0, 0, 0};
        run(40);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
